// File: rtl/mem_access_stage.sv
// MEM pipeline stage: data-memory load/store on an internal word RAM, branch resolution,
// and the MEM/WB register. After reset, the RAM is zero-filled one word per cycle while busy.
module mem_access_stage #(
    parameter int DATA_WIDTH     = 32,
    parameter int MEM_ADDR_WIDTH = 8,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int MEM_BUS_WIDTH  = 3,
    parameter int WB_BUS_WIDTH   = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [MEM_BUS_WIDTH-1:0]  memory_bus_in,
    input  logic [WB_BUS_WIDTH-1:0]   wb_bus_in,
    input  logic [DATA_WIDTH-1:0]     alu_result_in,
    input  logic                      alu_zero_flag_in,
    input  logic [DATA_WIDTH-1:0]     reg_rt_data_in,
    input  logic [REG_ADDR_WIDTH-1:0] add_reg_w_in,
    input  logic [DATA_WIDTH-1:0]     branch_target_in,
    output logic                      pc_src_out,
    output logic [DATA_WIDTH-1:0]     branch_target_out,
    output logic [DATA_WIDTH-1:0]     mem_read_data_out,
    output logic [DATA_WIDTH-1:0]     alu_result_out,
    output logic [REG_ADDR_WIDTH-1:0] add_reg_w_out,
    output logic [WB_BUS_WIDTH-1:0]   wb_bus_out,
    output logic                      mem_fault_out,
    output logic                      mem_busy_out
);

    localparam int DEPTH = 2 ** MEM_ADDR_WIDTH;

    typedef enum logic {
        S_CLEAR,
        S_RUN
    } state_t;

    state_t                    state_q, state_d;
    logic [MEM_ADDR_WIDTH-1:0] clear_idx_q, clear_idx_d;

    logic [DATA_WIDTH-1:0]     ram_q [DEPTH];

    logic [DATA_WIDTH-1:0]     rd_data_q, rd_data_d;
    logic [DATA_WIDTH-1:0]     alu_q, alu_d;
    logic [REG_ADDR_WIDTH-1:0] reg_w_q, reg_w_d;
    logic [WB_BUS_WIDTH-1:0]   wb_q, wb_d;
    logic                      fault_q, fault_d;

    logic                      busy;
    logic                      mem_wr, mem_rd, branch;
    logic                      addr_ok, access, fault, do_store, do_load;
    logic [MEM_ADDR_WIDTH-1:0] word_idx;

    logic                      ram_we;
    logic [MEM_ADDR_WIDTH-1:0] ram_waddr;
    logic [DATA_WIDTH-1:0]     ram_wdata;

    assign busy     = (state_q == S_CLEAR);
    assign mem_wr   = memory_bus_in[0];
    assign mem_rd   = memory_bus_in[1];
    assign branch   = memory_bus_in[2];

    // Word aligned and no byte-address bits beyond the RAM window.
    assign word_idx = alu_result_in[MEM_ADDR_WIDTH+1:2];
    assign addr_ok  = (alu_result_in[1:0] == 2'b00) &&
                      (alu_result_in[DATA_WIDTH-1:MEM_ADDR_WIDTH+2] == '0);
    assign access   = mem_rd | mem_wr;
    assign fault    = (mem_rd & mem_wr) | (access & ~addr_ok);
    assign do_store = ~busy & mem_wr & ~mem_rd & addr_ok;
    assign do_load  = ~busy & mem_rd & ~mem_wr & addr_ok;

    assign pc_src_out        = branch & alu_zero_flag_in & ~busy;
    assign branch_target_out = branch_target_in;

    // Clear sequencer
    always_comb begin
        state_d     = state_q;
        clear_idx_d = clear_idx_q;
        case (state_q)
            S_CLEAR: begin
                clear_idx_d = clear_idx_q + 1'b1;
                if (clear_idx_q == {MEM_ADDR_WIDTH{1'b1}}) begin
                    state_d = S_RUN;
                end
            end
            S_RUN:   state_d = S_RUN;
            default: state_d = S_CLEAR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_CLEAR;
            clear_idx_q <= '0;
        end else begin
            state_q     <= state_d;
            clear_idx_q <= clear_idx_d;
        end
    end

    // Single RAM write port shared by the clear sequencer and user stores.
    always_comb begin
        ram_we    = 1'b0;
        ram_waddr = word_idx;
        ram_wdata = reg_rt_data_in;
        if (!rst) begin
            if (busy) begin
                ram_we    = 1'b1;
                ram_waddr = clear_idx_q;
                ram_wdata = '0;
            end else if (do_store) begin
                ram_we    = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram_q[ram_waddr] <= ram_wdata;
        end
    end

    // MEM/WB register next-state
    always_comb begin
        rd_data_d = rd_data_q;
        alu_d     = alu_q;
        reg_w_d   = reg_w_q;
        wb_d      = '0;
        fault_d   = 1'b0;
        if (!busy) begin
            alu_d   = alu_result_in;
            reg_w_d = add_reg_w_in;
            wb_d    = wb_bus_in;
            if (fault) begin
                rd_data_d = '0;
                wb_d[1]   = 1'b0;
                fault_d   = 1'b1;
            end else if (do_load) begin
                rd_data_d = ram_q[word_idx];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q <= '0;
            alu_q     <= '0;
            reg_w_q   <= '0;
            wb_q      <= '0;
            fault_q   <= 1'b0;
        end else begin
            rd_data_q <= rd_data_d;
            alu_q     <= alu_d;
            reg_w_q   <= reg_w_d;
            wb_q      <= wb_d;
            fault_q   <= fault_d;
        end
    end

    assign mem_read_data_out = rd_data_q;
    assign alu_result_out    = alu_q;
    assign add_reg_w_out     = reg_w_q;
    assign wb_bus_out        = wb_q;
    assign mem_fault_out     = fault_q;
    assign mem_busy_out      = busy;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: clear sequencing, load/store, faults, branch, reset restart.
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  memory_bus_in;
    logic [1:0]  wb_bus_in;
    logic [31:0] alu_result_in;
    logic        alu_zero_flag_in;
    logic [31:0] reg_rt_data_in;
    logic [4:0]  add_reg_w_in;
    logic [31:0] branch_target_in;
    logic        pc_src_out;
    logic [31:0] branch_target_out;
    logic [31:0] mem_read_data_out;
    logic [31:0] alu_result_out;
    logic [4:0]  add_reg_w_out;
    logic [1:0]  wb_bus_out;
    logic        mem_fault_out;
    logic        mem_busy_out;

    int n_chk = 0;
    int n_err = 0;

    localparam logic [2:0] OP_NONE = 3'b000;
    localparam logic [2:0] OP_ST   = 3'b001;
    localparam logic [2:0] OP_LD   = 3'b010;
    localparam logic [2:0] OP_BR   = 3'b100;

    mem_access_stage dut (
        .clk               (clk),
        .rst               (rst),
        .memory_bus_in     (memory_bus_in),
        .wb_bus_in         (wb_bus_in),
        .alu_result_in     (alu_result_in),
        .alu_zero_flag_in  (alu_zero_flag_in),
        .reg_rt_data_in    (reg_rt_data_in),
        .add_reg_w_in      (add_reg_w_in),
        .branch_target_in  (branch_target_in),
        .pc_src_out        (pc_src_out),
        .branch_target_out (branch_target_out),
        .mem_read_data_out (mem_read_data_out),
        .alu_result_out    (alu_result_out),
        .add_reg_w_out     (add_reg_w_out),
        .wb_bus_out        (wb_bus_out),
        .mem_fault_out     (mem_fault_out),
        .mem_busy_out      (mem_busy_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Present one instruction, clock it in, settle just after the edge.
    task automatic op(input logic [2:0] mb, input logic [1:0] wb, input logic [31:0] alu,
                      input logic [31:0] rt, input logic [4:0] rd);
        memory_bus_in  = mb;
        wb_bus_in      = wb;
        alu_result_in  = alu;
        reg_rt_data_in = rt;
        add_reg_w_in   = rd;
        @(posedge clk);
        #1;
    endtask

    // Count busy cycles following a reset edge while offering a live instruction.
    task automatic count_busy(input string tag, input int max_cyc, output int cnt);
        cnt = 0;
        while (mem_busy_out && cnt < max_cyc) begin
            cnt++;
            if (cnt == 5) chk({tag, "_bubble_wb"}, {30'd0, wb_bus_out}, 32'd0);
            if (cnt == 6) chk({tag, "_bubble_flt"}, {31'd0, mem_fault_out}, 32'd0);
            op(OP_LD, 2'b11, 32'h0000_0006, 32'h0, 5'd3);
        end
    endtask

    initial begin
        int cnt;
        rst = 1'b1;
        memory_bus_in = '0; wb_bus_in = '0; alu_result_in = '0; alu_zero_flag_in = 1'b0;
        reg_rt_data_in = '0; add_reg_w_in = '0; branch_target_in = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state and clear duration
        chk("rst_busy",  {31'd0, mem_busy_out}, 32'd1);
        chk("rst_data",  mem_read_data_out, 32'd0);
        chk("rst_alu",   alu_result_out, 32'd0);
        chk("rst_wb",    {30'd0, wb_bus_out}, 32'd0);
        chk("rst_fault", {31'd0, mem_fault_out}, 32'd0);
        count_busy("clr1", 400, cnt);
        chk("clr1_cycles", cnt, 256);
        chk("clr1_regw_held", {27'd0, add_reg_w_out}, 32'd0);

        op(OP_LD, 2'b11, 32'h0000_0010, 32'h0, 5'd1);
        chk("ld10_data", mem_read_data_out, 32'd0);

        // Store then load
        op(OP_ST, 2'b00, 32'h0000_0004, 32'hDEAD_BEEF, 5'd0);
        op(OP_LD, 2'b11, 32'h0000_0004, 32'h0, 5'd7);
        chk("ld04_data",  mem_read_data_out, 32'hDEAD_BEEF);
        chk("ld04_wb",    {30'd0, wb_bus_out}, 32'd3);
        chk("ld04_regw",  {27'd0, add_reg_w_out}, 32'd7);
        chk("ld04_alu",   alu_result_out, 32'h0000_0004);
        chk("ld04_fault", {31'd0, mem_fault_out}, 32'd0);
        op(OP_NONE, 2'b10, 32'h1234_5678, 32'h0, 5'd9);
        chk("idle_hold",  mem_read_data_out, 32'hDEAD_BEEF);
        chk("idle_alu",   alu_result_out, 32'h1234_5678);

        // Top word, then out-of-range and misaligned accesses
        op(OP_ST, 2'b00, 32'h0000_03FC, 32'h1111_1111, 5'd0);
        op(OP_LD, 2'b11, 32'h0000_03FC, 32'h0, 5'd2);
        chk("ld3fc_data",  mem_read_data_out, 32'h1111_1111);
        chk("ld3fc_fault", {31'd0, mem_fault_out}, 32'd0);
        op(OP_LD, 2'b11, 32'h0000_0FFC, 32'h0, 5'd2);
        chk("ldffc_fault", {31'd0, mem_fault_out}, 32'd1);
        op(OP_LD, 2'b11, 32'h0000_0400, 32'h0, 5'd2);
        chk("ld400_fault", {31'd0, mem_fault_out}, 32'd1);
        chk("ld400_data",  mem_read_data_out, 32'd0);
        chk("ld400_wb",    {30'd0, wb_bus_out}, 32'd1);
        op(OP_LD, 2'b11, 32'h0000_0006, 32'h0, 5'd2);
        chk("ld006_fault", {31'd0, mem_fault_out}, 32'd1);
        chk("ld006_data",  mem_read_data_out, 32'd0);
        chk("ld006_wb",    {30'd0, wb_bus_out}, 32'd1);
        op(OP_ST, 2'b00, 32'h0000_0006, 32'h9999_9999, 5'd0);
        chk("st006_fault", {31'd0, mem_fault_out}, 32'd1);
        op(OP_NONE, 2'b00, 32'h0, 32'h0, 5'd0);
        chk("fault_pulse", {31'd0, mem_fault_out}, 32'd0);
        op(OP_LD, 2'b11, 32'h0000_0004, 32'h0, 5'd2);
        chk("ld04_unchanged", mem_read_data_out, 32'hDEAD_BEEF);
        op(OP_LD, 2'b11, 32'h0000_03FC, 32'h0, 5'd2);
        chk("ld3fc_unchanged", mem_read_data_out, 32'h1111_1111);

        // Branch resolution is combinational
        memory_bus_in = OP_BR; alu_zero_flag_in = 1'b1; branch_target_in = 32'h40;
        #1;
        chk("br_taken",  {31'd0, pc_src_out}, 32'd1);
        chk("br_target", branch_target_out, 32'h40);
        alu_zero_flag_in = 1'b0;
        #1;
        chk("br_not_taken", {31'd0, pc_src_out}, 32'd0);
        memory_bus_in = OP_NONE;

        // Read and write together
        op(OP_ST, 2'b00, 32'h0000_0008, 32'hA5A5_A5A5, 5'd0);
        op(OP_ST | OP_LD, 2'b11, 32'h0000_0008, 32'hFFFF_FFFF, 5'd4);
        chk("rw_fault", {31'd0, mem_fault_out}, 32'd1);
        chk("rw_wb",    {30'd0, wb_bus_out}, 32'd1);
        chk("rw_data",  mem_read_data_out, 32'd0);
        op(OP_LD, 2'b11, 32'h0000_0008, 32'h0, 5'd4);
        chk("rw_ram_kept", mem_read_data_out, 32'hA5A5_A5A5);

        // Reset mid-clear restarts the full sweep
        op(OP_ST, 2'b00, 32'h0000_0010, 32'h7777_7777, 5'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 100; i++) op(OP_NONE, 2'b00, 32'h0, 32'h0, 5'd0);
        chk("mid_busy", {31'd0, mem_busy_out}, 32'd1);
        memory_bus_in = OP_BR; alu_zero_flag_in = 1'b1;
        #1;
        chk("busy_no_branch", {31'd0, pc_src_out}, 32'd0);
        alu_zero_flag_in = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        count_busy("clr2", 400, cnt);
        chk("clr2_cycles", cnt, 256);
        op(OP_LD, 2'b11, 32'h0000_0010, 32'h0, 5'd1);
        chk("clr2_ld10", mem_read_data_out, 32'd0);
        op(OP_LD, 2'b11, 32'h0000_0004, 32'h0, 5'd1);
        chk("clr2_ld04", mem_read_data_out, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
